// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one logic-analyzer capture into a circular sample RAM.
// Tracks pre-trigger fill to drive armed, counts post-trigger samples, then
// parks in DONE with the final write address until the host acknowledges.
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clr_done,
  input  logic              wrt_smpl,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              busy,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] last_addr
);

  // One extra bit so the fill counter can hold ENTRIES even when ENTRIES == 2^ADDR_W.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  ENTRIES_C = CNT_W'(ENTRIES);
  localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] tp_q;
  logic [CNT_W-1:0]  smpl_cnt;
  logic [ADDR_W-1:0] post_cnt;

  logic [CNT_W-1:0]  smpl_cnt_inc;
  logic [ADDR_W-1:0] post_inc;
  logic [ADDR_W-1:0] waddr_inc;
  logic              arm_hit;
  logic              done_hit;

  // Clamp the requested post-trigger count into 1 .. ENTRIES-1 so at least one
  // pre-trigger slot and one post-trigger slot always exist.
  function automatic logic [ADDR_W-1:0] clamp_tp(input logic [ADDR_W-1:0] tpos);
    if (tpos == '0)
      return ADDR_W'(1);
    else if ({1'b0, tpos} >= ENTRIES_C)
      return LAST_C;
    else
      return tpos;
  endfunction

  // Write enable follows the strobe with no latency while capturing.
  assign we = (state == CAPTURE) && wrt_smpl;

  // Next-value arithmetic for the counters and the circular write pointer.
  always_comb begin
    smpl_cnt_inc = (smpl_cnt == ENTRIES_C) ? smpl_cnt : smpl_cnt + CNT_W'(1);
    post_inc     = post_cnt + ADDR_W'(1);
    waddr_inc    = (waddr == LAST_C) ? '0 : waddr + ADDR_W'(1);
    arm_hit      = smpl_cnt_inc >= (ENTRIES_C - {1'b0, tp_q});
    done_hit     = wrt_smpl && triggered && (post_inc == tp_q);
  end

  // Capture FSM with registered status outputs; completion beats abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      tp_q             <= '0;
      smpl_cnt         <= '0;
      post_cnt         <= '0;
      waddr            <= '0;
      last_addr        <= '0;
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
      capture_done     <= 1'b0;
      busy             <= 1'b0;
    end else begin
      set_capture_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= CAPTURE;
            busy     <= 1'b1;
            tp_q     <= clamp_tp(trig_pos);
            waddr    <= '0;
            smpl_cnt <= '0;
            post_cnt <= '0;
            armed    <= 1'b0;
          end
        end
        CAPTURE: begin
          if (wrt_smpl) begin
            waddr    <= waddr_inc;
            smpl_cnt <= smpl_cnt_inc;
            if (arm_hit)
              armed <= 1'b1;
            if (triggered)
              post_cnt <= post_inc;
          end
          if (done_hit) begin
            state            <= DONE;
            busy             <= 1'b0;
            capture_done     <= 1'b1;
            set_capture_done <= 1'b1;
            last_addr        <= waddr;
            armed            <= 1'b0;
          end else if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b0;
          end
        end
        DONE: begin
          if (clr_done) begin
            state        <= IDLE;
            capture_done <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          capture_done <= 1'b0;
          armed        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequencing controller for one logic-analyzer capture. It starts a capture on host command and writes decimated samples into the circular sample RAM. It asserts `armed` to the trigger block once enough pre-trigger history is stored, then counts post-trigger samples after `triggered`. It ends the capture with a one-cycle `set_capture_done`, which releases the trigger block, and reports the final write address so the readback engine can unroll the buffer.

## Interface
- `ENTRIES`, 384: sample RAM depth in words. Must be ≥ 4.
- `ADDR_W`, 9: address width. Requires 2^ADDR_W ≥ ENTRIES.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `run` input 1: level from the config register; capture enabled.
- `clr_done` input 1: one-cycle pulse from the host; acknowledges a finished capture.
- `wrt_smpl` input 1: one-cycle strobe; a decimated sample is valid this cycle.
- `trig_pos` input ADDR_W: requested number of post-trigger samples.
- `triggered` input 1: registered trigger status from the trigger block.
- `armed` output 1: pre-trigger history complete; trigger is allowed.
- `set_capture_done` output 1: one-cycle pulse; capture finished.
- `capture_done` output 1: level; a finished capture is awaiting readback.
- `busy` output 1: state is CAPTURE.
- `we` output 1: sample RAM write enable.
- `waddr` output ADDR_W: sample RAM write address.
- `last_addr` output ADDR_W: address of the final sample of the last completed capture.

## Operation
- States: IDLE, CAPTURE, DONE. Encoding is free.
- Effective post-trigger count `tp`:
  - `trig_pos` = 0 gives `tp` = 1.
  - `trig_pos` ≥ ENTRIES gives `tp` = ENTRIES−1.
  - Otherwise `tp` = `trig_pos`.
  - `tp` is sampled on the IDLE→CAPTURE transition and held for the whole capture.
- IDLE:
  - `run`=1 moves to CAPTURE.
  - On that entry: `waddr`←0, `smpl_cnt`←0, `post_cnt`←0, `armed`←0.
- CAPTURE:
  - `we` = `wrt_smpl`, combinational. The write goes to the current `waddr`.
  - On each `wrt_smpl`, `waddr` increments and wraps from ENTRIES−1 to 0.
  - `smpl_cnt` counts samples written and saturates at ENTRIES.
  - `armed` is registered. It sets when `smpl_cnt` ≥ ENTRIES−`tp` (using the post-increment count) and stays set until the state leaves CAPTURE.
  - Post-trigger counting: a `wrt_smpl` with `triggered`=1 increments `post_cnt`. The strobe in the cycle `triggered` first reads 1 counts as post-trigger sample 1.
  - Completion: when the incremented `post_cnt` equals `tp`, on the same edge:
    - `last_addr`←current `waddr`.
    - `set_capture_done`←1 for one cycle.
    - state→DONE.
  - Abort: `run`=0 moves to IDLE without a pulse and leaves `last_addr` unchanged. If abort and completion fall on the same edge, completion wins.
- DONE:
  - `we`=0. `wrt_smpl` is ignored and `waddr` is frozen.
  - `capture_done`=1.
  - `clr_done` moves to IDLE. If `run` is still 1 on the following cycle, the next capture starts.
  - `run`=0 alone does not leave DONE.
- `clr_done` in IDLE or CAPTURE is ignored.
- `busy` = (state==CAPTURE). `capture_done` = (state==DONE).

## Timing
- Reset values:
  - State IDLE.
  - `armed`=0, `set_capture_done`=0, `capture_done`=0, `busy`=0, `we`=0.
  - `waddr`=0, `last_addr`=0, internal counters 0.
- Reset mid-capture aborts immediately. No `set_capture_done` pulse is produced.
- `run` rising edge to `busy`=1: 1 cycle.
- `we` is combinational with zero latency from `wrt_smpl`. All other outputs are registered.
- `armed` rises on the edge of the qualifying `wrt_smpl`. It is visible in the next cycle.
- The trigger block takes one further cycle to raise `triggered`. Samples strobed before `triggered` reads 1 are pre-trigger.
- `set_capture_done` is high for exactly one cycle, the cycle after the final write. `capture_done` rises in the same cycle.
- The final write's address equals `last_addr`. The oldest sample sits at (`last_addr`+1) mod ENTRIES once the buffer has filled.
- Because the trigger requires `armed`, a completed capture always has ≥ ENTRIES−`tp` pre-trigger samples and exactly `tp` post-trigger samples. The count is modulo the trigger block honouring `armed`.

## Test plan
- Fill and arm: ENTRIES=8, `trig_pos`=3, `run`=1, `wrt_smpl` every 2nd cycle, `triggered`=0 → `we` pulses at `waddr` 0..7 then 0 again (wrap). `armed` becomes visible after the 5th write and stays high.
- Trigger and complete: continue the above and raise `triggered` after 10 writes → exactly 3 further writes occur. Single-cycle `set_capture_done` the cycle after the 3rd. `capture_done`=1. `last_addr`=4. No `we` afterwards.
- Clamp: `trig_pos`=0 → completes on the first triggered write. `trig_pos`=20 with ENTRIES=8 → `armed` after the 1st write and 7 post-trigger writes.
- Abort: drop `run` mid-capture with `triggered`=1 → IDLE next cycle, no `set_capture_done`, `last_addr` unchanged. Raise `run` again → `waddr` restarts at 0.
- Done hold and re-arm: in DONE apply 5 `wrt_smpl` → no `we`, `waddr` frozen. Pulse `clr_done` with `run`=1 → IDLE, then CAPTURE the next cycle.
- Async reset while `busy` and `armed` → all outputs at reset values immediately, without a clock edge.
